// File: rtl/pie_pkg.sv
// rtl/pie_pkg.sv - shared PIE state codes and T-derived thresholds for encoder and decoder
package pie_pkg;

  // Decoder FSM state codes
  typedef logic [1:0] pie_state_t;
  localparam pie_state_t IDLE = 2'd0;
  localparam pie_state_t LOW  = 2'd1;
  localparam pie_state_t HIGH = 2'd2;

  // Shortest high pulse accepted as a symbol (T)
  function automatic int min_high(input int t);
    return t;
  endfunction

  // Split point between data-0 and data-1 highs (3T)
  function automatic int pivot_high(input int t);
    return 3 * t;
  endfunction

  // Longest legal high pulse (6T)
  function automatic int max_high(input int t);
    return 6 * t;
  endfunction

  // Low gap beyond which the frame is considered ended (2T)
  function automatic int eof_gap(input int t);
    return 2 * t;
  endfunction

  // Encoder-side symbol lengths: data-0 high 2T, data-1 high 4T, low T
  function automatic int data0_high(input int t);
    return 2 * t;
  endfunction

  function automatic int data1_high(input int t);
    return 4 * t;
  endfunction

  function automatic int sym_low(input int t);
    return t;
  endfunction

endpackage

// File: rtl/pie_out_reg.sv
// rtl/pie_out_reg.sv - one-entry valid/ready bit register with overrun detection
module pie_out_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic load_vld,
  input  logic load_bit,
  input  logic out_rdy,
  output logic out_bit,
  output logic out_vld,
  output logic overrun
);

  // A new bit is refused only when the held bit is not being taken this cycle
  assign overrun = load_vld && out_vld && !out_rdy;

  // Load a new bit, drain on handshake, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bit <= 1'b0;
      out_vld <= 1'b0;
    end else if (load_vld && (!out_vld || out_rdy)) begin
      out_bit <= load_bit;
      out_vld <= 1'b1;
    end else if (out_vld && out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/pie_decoder.sv
// rtl/pie_decoder.sv - PIE receive decoder: run-length FSM, high-pulse classifier, bit output
module pie_decoder
  import pie_pkg::*;
#(
  parameter int THIRD_TARI = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_pie,
  input  logic in_vld,
  output logic out_bit,
  output logic out_vld,
  input  logic out_rdy,
  output logic out_eof,
  output logic out_err
);

  localparam int CW = $clog2(6 * THIRD_TARI + 2);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] MIN_H   = CW'(min_high(THIRD_TARI));
  localparam logic [CW-1:0] PIVOT   = CW'(pivot_high(THIRD_TARI));
  localparam logic [CW-1:0] MAX_H   = CW'(max_high(THIRD_TARI));
  localparam logic [CW-1:0] EOF_GAP = CW'(eof_gap(THIRD_TARI));
  localparam logic [CW-1:0] EOF_SAT = CW'(eof_gap(THIRD_TARI) + 1);

  pie_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          dec_vld, dec_bit, eof_set, fault, overrun;

  // Next-state, run counter and classification for the current strobe
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dec_vld = 1'b0;
    dec_bit = 1'b0;
    eof_set = 1'b0;
    fault   = 1'b0;
    if (in_vld) begin
      case (state)
        IDLE: begin
          if (!in_pie) begin
            state_d = LOW;
            cnt_d   = ONE;
          end
        end
        LOW: begin
          if (in_pie) begin
            state_d = HIGH;
            cnt_d   = ONE;
          end else if (cnt < EOF_SAT) begin
            cnt_d   = cnt + ONE;
            eof_set = (cnt == EOF_GAP);
          end
        end
        HIGH: begin
          if (in_pie) begin
            if (cnt >= MAX_H) begin
              state_d = IDLE;
              cnt_d   = '0;
              fault   = 1'b1;
            end else begin
              cnt_d = cnt + ONE;
            end
          end else begin
            state_d = LOW;
            cnt_d   = ONE;
            if (cnt < MIN_H) begin
              fault = 1'b1;
            end else begin
              dec_vld = 1'b1;
              dec_bit = (cnt >= PIVOT);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM, counter and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      out_eof <= 1'b0;
      out_err <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      out_eof <= eof_set;
      out_err <= fault || overrun;
    end
  end

  pie_out_reg u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_vld (dec_vld),
    .load_bit (dec_bit),
    .out_rdy  (out_rdy),
    .out_bit  (out_bit),
    .out_vld  (out_vld),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_pie_decoder.sv
// tb/tb_pie_decoder.sv - self-checking bench for pie_decoder at THIRD_TARI=2
module tb_pie_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_pie = 1'b0;
  logic in_vld = 1'b0;
  logic out_rdy = 1'b1;
  logic out_bit, out_vld, out_eof, out_err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int eof_seen = 0;
  int got[$];

  typedef struct {
    int high_len;
    int low_len;
    int exp_bit;   // -1: no bit expected
    int exp_err;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  pie_decoder #(.THIRD_TARI(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_pie  (in_pie),
    .in_vld  (in_vld),
    .out_bit (out_bit),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_eof (out_eof),
    .out_err (out_err)
  );

  // Collect delivered bits and status pulses mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_vld && out_rdy) got.push_back(int'(out_bit));
      if (out_err) err_seen++;
      if (out_eof) eof_seen++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      in_pie = lvl;
      in_vld = 1'b1;
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sym(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  function automatic int got_at(input int i);
    return (got.size() > i) ? got[i] : -1;
  endfunction

  initial begin
    int lb_bits[5];
    int eof_idx;

    lb_bits = '{1, 0, 1, 1, 0};
    // T=2: bit 0 for h in 2..5, bit 1 for h in 6..12, glitch below 2, overlong at 13
    vecs[0] = '{1, 2, -1, 1};
    vecs[1] = '{8, 2, 1, 0};
    vecs[2] = '{2, 2, 0, 0};
    vecs[3] = '{5, 2, 0, 0};
    vecs[4] = '{6, 2, 1, 0};
    vecs[5] = '{12, 2, 1, 0};
    vecs[6] = '{13, 2, -1, 1};
    vecs[7] = '{4, 2, 0, 0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset out_bit", int'(out_bit), 0);
    check("reset out_vld", int'(out_vld), 0);
    check("reset out_eof", int'(out_eof), 0);
    check("reset out_err", int'(out_err), 0);
    rst_n = 1'b1;

    // Loopback: sync symbol (lost in IDLE) then 1,0,1,1,0 encoded as 4T/2T highs, T lows
    sym(8, 2);
    foreach (lb_bits[i]) sym(lb_bits[i] ? 8 : 4, 2);
    idle(3);
    check("loopback count", got.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("loopback bit%0d", i), got_at(i), lb_bits[i]);
    check("loopback err", err_seen, 0);

    // Table of single symbols from LOW state
    for (int v = 0; v < 8; v++) begin
      got.delete();
      err_seen = 0;
      sym(vecs[v].high_len, vecs[v].low_len);
      idle(2);
      check($sformatf("vec%0d h=%0d count", v, vecs[v].high_len), got.size(),
            (vecs[v].exp_bit < 0) ? 0 : 1);
      if (vecs[v].exp_bit >= 0)
        check($sformatf("vec%0d h=%0d bit", v, vecs[v].high_len), got_at(0), vecs[v].exp_bit);
      check($sformatf("vec%0d h=%0d err", v, vecs[v].high_len), err_seen, vecs[v].exp_err);
    end

    // Long low gap: eof once on the 5th low strobe, then a high of 8 decodes as 1
    got.delete();
    eof_seen = 0;
    eof_idx = 0;
    drive(1'b1, 4);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1);
      if (out_eof && eof_idx == 0) eof_idx = i;
    end
    sym(8, 2);
    idle(2);
    check("eof count", eof_seen, 1);
    check("eof strobe", eof_idx, 5);
    check("eof bits", got.size(), 2);
    check("eof bit before gap", got_at(0), 0);
    check("eof bit after gap", got_at(1), 1);

    // Overrun: consumer stalled across bits 0 then 1
    out_rdy = 1'b0;
    got.delete();
    err_seen = 0;
    sym(4, 2);
    sym(8, 2);
    idle(2);
    check("overrun out_vld", int'(out_vld), 1);
    check("overrun out_bit", int'(out_bit), 0);
    check("overrun err", err_seen, 1);
    out_rdy = 1'b1;
    idle(3);
    check("overrun delivered", got.size(), 1);
    check("overrun delivered bit", got_at(0), 0);
    check("overrun drained", int'(out_vld), 0);

    // Reset mid-high with a bit pending
    out_rdy = 1'b0;
    sym(4, 2);
    drive(1'b1, 3);
    in_pie = 1'b1;
    check("pre-reset out_vld", int'(out_vld), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_vld", int'(out_vld), 0);
    check("async reset out_bit", int'(out_bit), 0);
    check("async reset out_eof", int'(out_eof), 0);
    check("async reset out_err", int'(out_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_rdy = 1'b1;
    got.delete();
    err_seen = 0;
    sym(8, 2);
    sym(4, 2);
    idle(2);
    check("post-reset count", got.size(), 1);
    check("post-reset bit", got_at(0), 0);
    check("post-reset err", err_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
